// File: rtl/sw_input_port.sv
// Switch-bank input port: synchronises and debounces the load strobe, captures the
// data byte once per debounced press and offers it through a valid/read handshake.
module sw_input_port #(
    parameter int DATA_W     = 8,
    parameter int DEB_CYCLES = 1000,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_strobe,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic              strobe_deb
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    logic              r_strobe_s1;
    logic              r_strobe_s2;
    logic [DATA_W-1:0] r_data_s1;
    logic [DATA_W-1:0] r_data_s2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_strobe_deb;
    state_t            r_state;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_overrun;

    logic w_differs;
    logic w_cnt_done;
    logic w_deb_rise;
    logic w_deb_fall;

    // Two-flop synchronisers for the asynchronous switch inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_s1 <= 1'b0;
            r_strobe_s2 <= 1'b0;
            r_data_s1   <= '0;
            r_data_s2   <= '0;
        end else begin
            r_strobe_s1 <= sw_strobe;
            r_strobe_s2 <= r_strobe_s1;
            r_data_s1   <= sw_data;
            r_data_s2   <= r_data_s1;
        end
    end

    assign w_differs  = (r_strobe_s2 != r_strobe_deb);
    assign w_cnt_done = (r_cnt == LP_CNT_MAX);
    assign w_deb_rise = w_differs & w_cnt_done & r_strobe_s2;
    assign w_deb_fall = w_differs & w_cnt_done & ~r_strobe_s2;

    // Debounce: the level must differ for DEB_CYCLES consecutive cycles to flip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_strobe_deb <= 1'b0;
        end else if (!w_differs) begin
            r_cnt <= '0;
        end else if (w_cnt_done) begin
            r_strobe_deb <= r_strobe_s2;
            r_cnt        <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Press FSM; capture happens on the same edge the debounced strobe rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_deb_rise) begin
                        r_state      <= ST_PRESSED;
                        r_data_out   <= r_data_s2;
                        r_data_valid <= 1'b1;
                        // Overrun set takes priority over a simultaneous clear
                        if (r_data_valid && !rd_en) begin
                            r_overrun <= 1'b1;
                        end else if (clr_ovr) begin
                            r_overrun <= 1'b0;
                        end
                    end else begin
                        if (rd_en) begin
                            r_data_valid <= 1'b0;
                        end
                        if (clr_ovr) begin
                            r_overrun <= 1'b0;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (w_deb_fall) begin
                        r_state <= ST_IDLE;
                    end
                    if (rd_en) begin
                        r_data_valid <= 1'b0;
                    end
                    if (clr_ovr) begin
                        r_overrun <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;
    assign strobe_deb = r_strobe_deb;

endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port with a short debounce window (16 cycles).
module tb_sw_input_port;

    localparam int DW  = 8;
    localparam int DEB = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] sw_data;
    logic          sw_strobe;
    logic          rd_en;
    logic          clr_ovr;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          overrun;
    logic          strobe_deb;

    int total;
    int bad;
    int cap_cnt;
    logic dv_q;

    sw_input_port #(.DATA_W(DW), .DEB_CYCLES(DEB), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_data    (sw_data),
        .sw_strobe  (sw_strobe),
        .rd_en      (rd_en),
        .clr_ovr    (clr_ovr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .strobe_deb (strobe_deb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges of data_valid (captures that reached an empty port)
    always @(posedge clk) begin
        dv_q <= data_valid;
        if (data_valid && !dv_q) cap_cnt <= cap_cnt + 1;
    end

    // Advance n clock edges and land 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [DW-1:0] d, input int hold);
        sw_data   = d;
        sw_strobe = 1'b1;
        step(hold);
    endtask

    task automatic release_sw(input int hold);
        sw_strobe = 1'b0;
        step(hold);
    endtask

    task automatic read_pulse();
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        total++;
        if ({data_out, data_valid, overrun, strobe_deb} !== {8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h dv=%b ovr=%b deb=%b want all 0",
                     data_out, data_valid, overrun, strobe_deb);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_latency();
        press(8'hA5, 17);
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: dv=%b after 17 edges, want 0", data_valid);
        end
        step(1);
        total++;
        if ({data_valid, data_out, strobe_deb, overrun} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL latency_capture: dv=%b data=%h deb=%b ovr=%b want 1 a5 1 0",
                     data_valid, data_out, strobe_deb, overrun);
        end
        step(82);
        release_sw(30);
        total++;
        if (strobe_deb !== 1'b0) begin
            bad++;
            $display("FAIL release_deb: deb=%b want 0", strobe_deb);
        end
        read_pulse();
    endtask

    task automatic test_glitch();
        press(8'h5A, 10);
        release_sw(5);
        press(8'h5A, 10);
        release_sw(20);
        total++;
        if ({data_valid, strobe_deb} !== 2'b00) begin
            bad++;
            $display("FAIL glitch_no_capture: dv=%b deb=%b want 0 0", data_valid, strobe_deb);
        end
        press(8'h6B, 20);
        total++;
        if ({data_valid, data_out} !== {1'b1, 8'h6B}) begin
            bad++;
            $display("FAIL glitch_then_stable: dv=%b data=%h want 1 6b", data_valid, data_out);
        end
        release_sw(30);
        read_pulse();
    endtask

    task automatic test_read();
        press(8'h3C, 30);
        release_sw(30);
        read_pulse();
        total++;
        if ({data_valid, data_out} !== {1'b0, 8'h3C}) begin
            bad++;
            $display("FAIL read_clear: dv=%b data=%h want 0 3c", data_valid, data_out);
        end
        read_pulse();
        total++;
        if ({data_valid, data_out, overrun} !== {1'b0, 8'h3C, 1'b0}) begin
            bad++;
            $display("FAIL read_idle: dv=%b data=%h ovr=%b want 0 3c 0",
                     data_valid, data_out, overrun);
        end
    endtask

    task automatic test_overrun();
        press(8'h11, 30);
        release_sw(30);
        total++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h11, 1'b0}) begin
            bad++;
            $display("FAIL ovr_first: dv=%b data=%h ovr=%b want 1 11 0",
                     data_valid, data_out, overrun);
        end
        press(8'h22, 30);
        total++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h22, 1'b1}) begin
            bad++;
            $display("FAIL ovr_set: dv=%b data=%h ovr=%b want 1 22 1",
                     data_valid, data_out, overrun);
        end
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        total++;
        if ({overrun, data_valid} !== 2'b01) begin
            bad++;
            $display("FAIL ovr_clear: ovr=%b dv=%b want 0 1", overrun, data_valid);
        end
        release_sw(30);
        read_pulse();
    endtask

    task automatic test_back_to_back();
        press(8'h55, 30);
        release_sw(30);
        press(8'h77, 17);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        total++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h77, 1'b0}) begin
            bad++;
            $display("FAIL read_on_capture: dv=%b data=%h ovr=%b want 1 77 0",
                     data_valid, data_out, overrun);
        end
        release_sw(30);
        // Data still unread: a capture with clr_ovr on the same edge must set overrun
        press(8'h99, 17);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        total++;
        if ({data_valid, data_out, overrun} !== {1'b1, 8'h99, 1'b1}) begin
            bad++;
            $display("FAIL set_beats_clear: dv=%b data=%h ovr=%b want 1 99 1",
                     data_valid, data_out, overrun);
        end
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        release_sw(30);
        read_pulse();
        total++;
        if ({data_valid, overrun} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_cleanup: dv=%b ovr=%b want 0 0", data_valid, overrun);
        end
    endtask

    task automatic test_reset_mid();
        press(8'hC3, 12);
        rst = 1'b1;
        step(3);
        total++;
        if ({data_out, data_valid, overrun, strobe_deb} !== {8'h00, 3'b000}) begin
            bad++;
            $display("FAIL reset_mid_outputs: data=%h dv=%b ovr=%b deb=%b want all 0",
                     data_out, data_valid, overrun, strobe_deb);
        end
        rst = 1'b0;
        step(17);
        total++;
        if (data_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_early: dv=%b want 0", data_valid);
        end
        step(1);
        total++;
        if ({data_valid, data_out, strobe_deb} !== {1'b1, 8'hC3, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_recapture: dv=%b data=%h deb=%b want 1 c3 1",
                     data_valid, data_out, strobe_deb);
        end
        release_sw(30);
        read_pulse();
    endtask

    task automatic test_many_presses();
        int start;
        int wrong;
        wrong = 0;
        start = cap_cnt;
        for (int p = 0; p < 10; p++) begin
            // Bouncy leading edge before settling high
            for (int b = 0; b < 4; b++) begin
                press(8'(8'h40 + p), 3);
                release_sw(2);
            end
            press(8'(8'h40 + p), 40);
            if (data_out !== 8'(8'h40 + p)) wrong++;
            read_pulse();
            release_sw(40);
            if (data_valid !== 1'b0) wrong++;
        end
        step(2);
        total++;
        if (cap_cnt - start !== 10) begin
            bad++;
            $display("FAIL presses_count: captures=%0d want 10", cap_cnt - start);
        end
        total++;
        if (wrong !== 0) begin
            bad++;
            $display("FAIL presses_data: wrong=%0d want 0", wrong);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cap_cnt   = 0;
        dv_q      = 1'b0;
        rst       = 1'b1;
        sw_data   = '0;
        sw_strobe = 1'b0;
        rd_en     = 1'b0;
        clr_ovr   = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_glitch();
        test_read();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_many_presses();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
- Board-side receiver for the switch bank that feeds PICO_MIPS's input port.
- sw[7:0] carries data and sw[8] is a manually operated "load" strobe, held for thousands of cycles per press.
- The block synchronises and debounces the strobe, then captures the data byte on each debounced press.
- It presents the byte to the CPU through a valid/read handshake and flags overruns.

Parameters:
- DATA_W, 8, width of switch data bus and captured byte.
- DEB_CYCLES, 1000, consecutive stable synchronised cycles needed before the debounced strobe changes state (>=2).
- CNT_W, 10, width of debounce counter; must satisfy 2^CNT_W >= DEB_CYCLES.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- sw_data, input, DATA_W, raw asynchronous switch data.
- sw_strobe, input, 1, raw asynchronous load switch (sw[8]).
- rd_en, input, 1, CPU read of the input port (single-cycle pulse or level).
- clr_ovr, input, 1, clears the sticky overrun flag.
- data_out, output, DATA_W, last captured byte.
- data_valid, output, 1, data_out holds an unread byte.
- overrun, output, 1, sticky: a byte was captured while the previous byte was unread.
- strobe_deb, output, 1, debounced strobe level (for LED mirroring).

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops = 0, counter = 0, FSM = IDLE.
  - data_out = 0, data_valid = 0, overrun = 0, strobe_deb = 0.
- Synchronisation:
  - sw_strobe and sw_data each pass through 2 flops, giving s_strobe and s_data.
  - Only s_* are used downstream.
- Debounce counter, evaluated every cycle:
  - If s_strobe == strobe_deb: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: strobe_deb <= s_strobe, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEB_CYCLES resets the count and produces no change.
- FSM:
  - IDLE (strobe_deb = 0) -> PRESSED on the edge where strobe_deb goes 0->1.
  - PRESSED -> IDLE on the edge where strobe_deb goes 1->0.
  - Exactly one capture per press. Releasing never captures.
- Capture, on the IDLE->PRESSED edge:
  - data_out <= s_data and data_valid <= 1.
  - Latency: raw strobe rising edge to data_valid = 1 is 2 + DEB_CYCLES cycles, provided the strobe stays stable.
  - The captured byte is the s_data value at that edge.
- Read:
  - rd_en = 1 while data_valid = 1 clears data_valid on the next edge. data_out keeps its value.
  - rd_en while data_valid = 0 has no effect.
- Overrun:
  - A capture while data_valid = 1 and rd_en = 0 sets overrun = 1 and overwrites data_out with the new byte.
- Capture and rd_en in the same cycle:
  - The new byte is loaded, data_valid stays 1, overrun is unchanged.
- Overrun clear:
  - clr_ovr = 1 clears overrun next edge.
  - If clr_ovr and a new overrun occur in the same cycle, set wins (overrun = 1).
- Reset mid-debounce or mid-press: all state returns to reset values immediately.
  - After release, if the strobe is still high, a new debounce and capture occurs (2 + DEB_CYCLES cycles later).
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan (DEB_CYCLES = 16 unless stated):
- Reset, then hold sw_data = 8'hA5, raise sw_strobe and hold 100 cycles -> data_valid rises exactly 18 cycles after the first sampling edge with strobe high; data_out = 8'hA5; strobe_deb = 1; overrun = 0.
- Toggle sw_strobe high for 10 cycles, low 5, high 10 -> no capture, data_valid stays 0. Then a stable 20-cycle high -> one capture.
- Capture 8'h3C, pulse rd_en one cycle -> data_valid = 0 next cycle, data_out still 8'h3C. A second rd_en -> no change.
- Capture 8'h11, no read, release, then press with 8'h22 -> data_out = 8'h22, data_valid = 1, overrun = 1. Pulse clr_ovr -> overrun = 0.
- rd_en asserted on the exact capture cycle of the second byte 8'h77 -> data_valid = 1, data_out = 8'h77, overrun = 0.
- Assert rst at cnt = 10 during a press, release with strobe still high -> all outputs 0 during reset. Capture occurs 18 cycles after reset release. With DEB_CYCLES = 1000 and 15000-cycle press/release periods, exactly one capture per press over 10 presses.
